// File: rtl/csr_trap_file.sv
// csr_trap_file: machine-mode CSR register file with trap-entry / MRET sequencing and EX-stage writes.
// Optional feature macro CSR_COUNTERS_EN adds mcycle, minstret and mhpmcounter3+ (32-bit half access).
module csr_trap_file #(
  parameter int unsigned NUM_HPM   = 2,
  parameter int unsigned CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [11:0]                              csr_ra_id,
  output logic [31:0]                              csr_rd,
  output logic                                     csr_illegal,
  input  logic                                     csr_we_ex,
  input  logic [1:0]                               csr_op_ex,
  input  logic [11:0]                              csr_wa_ex,
  input  logic [31:0]                              csr_wd_ex,
  input  logic                                     instret_ex,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_evt,
  input  logic                                     trap_valid,
  input  logic [31:0]                              trap_cause,
  input  logic [31:0]                              trap_pc,
  input  logic                                     mret_valid,
  output logic [31:0]                              mtvec_o,
  output logic [31:0]                              mepc_o,
  output logic [31:0]                              mstatus_o,
  output logic                                     irq_enable
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] MST_WMASK  = 32'h0000_0088;
  localparam logic [31:0] MST_FIXED  = 32'h0000_1800;

  logic        mie_bit_q, mie_bit_d;
  logic        mpie_bit_q, mpie_bit_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic [31:0] mstatus_rd;
  logic [31:0] wr_old, wr_new, wr_val;
  logic        wr_req, wr_en, bypass;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_bit_q, 3'b0, mie_bit_q, 3'b0};

`ifdef CSR_COUNTERS_EN
  localparam int unsigned NCNT    = NUM_HPM + 2;
  localparam logic [31:0] HI_MASK = 32'((64'd1 << (CNT_W - 32)) - 64'd1);

  // Index 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]  cnt_inc;
  logic             unused_evt;

  assign unused_evt = ^hpm_evt;

  function automatic logic [11:0] cnt_addr(input int unsigned k, input logic hi);
    logic [11:0] a;
    a = (k == 0) ? 12'hB00 : (12'hB01 + 12'(k));
    return hi ? (a | 12'h080) : a;
  endfunction

  function automatic logic [31:0] cnt_half(input logic [CNT_W-1:0] c, input logic hi);
    logic [63:0] ext;
    ext = 64'(c);
    return hi ? ext[63:32] : ext[31:0];
  endfunction
`else
  logic unused_evt;

  assign unused_evt = ^{instret_ex, hpm_evt};
`endif

  function automatic logic csr_impl(input logic [11:0] a);
    logic hit;
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
      A_MEPC, A_MCAUSE, A_MHARTID: hit = 1'b1;
      default:                     hit = 1'b0;
    endcase
`ifdef CSR_COUNTERS_EN
    for (int unsigned k = 0; k < NCNT; k++) begin
      if ((a == cnt_addr(k, 1'b0)) || (a == cnt_addr(k, 1'b1))) hit = 1'b1;
    end
`endif
    return hit;
  endfunction

  function automatic logic [31:0] csr_value(input logic [11:0] a);
    logic [31:0] v;
    case (a)
      A_MSTATUS:  v = mstatus_rd;
      A_MIE:      v = mie_q;
      A_MTVEC:    v = mtvec_q;
      A_MSCRATCH: v = mscratch_q;
      A_MEPC:     v = mepc_q;
      A_MCAUSE:   v = mcause_q;
      default:    v = '0;
    endcase
`ifdef CSR_COUNTERS_EN
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (a == cnt_addr(k, 1'b0))      v = cnt_half(cnt_q[k], 1'b0);
      else if (a == cnt_addr(k, 1'b1)) v = cnt_half(cnt_q[k], 1'b1);
    end
`endif
    return v;
  endfunction

  // Value as it will actually be stored (and read back) at address a.
  function automatic logic [31:0] csr_masked(input logic [11:0] a, input logic [31:0] v);
    logic [31:0] m;
    case (a)
      A_MSTATUS:             m = (v & MST_WMASK) | MST_FIXED;
      A_MIE:                 m = v & MIE_MASK;
      A_MTVEC, A_MEPC:       m = v & ~32'd3;
      A_MSCRATCH, A_MCAUSE:  m = v;
      default:               m = '0;
    endcase
`ifdef CSR_COUNTERS_EN
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (a == cnt_addr(k, 1'b0))      m = v;
      else if (a == cnt_addr(k, 1'b1)) m = v & HI_MASK;
    end
`endif
    return m;
  endfunction

  assign wr_req = csr_we_ex && (csr_op_ex != 2'b00);
  assign wr_en  = wr_req && !trap_valid && !mret_valid;
  assign bypass = wr_en && (csr_wa_ex == csr_ra_id);

  always_comb begin
    wr_old = csr_value(csr_wa_ex);
    case (csr_op_ex)
      2'b01:   wr_new = csr_wd_ex;
      2'b10:   wr_new = wr_old | csr_wd_ex;
      2'b11:   wr_new = wr_old & ~csr_wd_ex;
      default: wr_new = wr_old;
    endcase
    wr_val = csr_masked(csr_wa_ex, wr_new);
  end

  always_comb begin
    csr_rd      = bypass ? wr_val : csr_value(csr_ra_id);
    csr_illegal = !csr_impl(csr_ra_id);
  end

  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_bit_d = mpie_bit_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_valid) begin
      mepc_d     = trap_pc & ~32'd3;
      mcause_d   = trap_cause;
      mpie_bit_d = mie_bit_q;
      mie_bit_d  = 1'b0;
    end else if (mret_valid) begin
      mie_bit_d  = mpie_bit_q;
      mpie_bit_d = 1'b1;
    end else if (wr_en) begin
      case (csr_wa_ex)
        A_MSTATUS: begin
          mie_bit_d  = wr_val[3];
          mpie_bit_d = wr_val[7];
        end
        A_MIE:      mie_d      = wr_val;
        A_MTVEC:    mtvec_d    = wr_val;
        A_MSCRATCH: mscratch_d = wr_val;
        A_MEPC:     mepc_d     = wr_val;
        A_MCAUSE:   mcause_d   = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & ~32'd3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_bit_q <= mpie_bit_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A committed write to either half takes precedence over that counter's increment.
  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inc[1] = instret_ex;
    for (int unsigned i = 0; i < NUM_HPM; i++) cnt_inc[i+2] = hpm_evt[i];
    for (int unsigned k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(cnt_inc[k]);
      if (wr_en && (csr_wa_ex == cnt_addr(k, 1'b0)))
        cnt_d[k] = {cnt_q[k][CNT_W-1:32], wr_val};
      else if (wr_en && (csr_wa_ex == cnt_addr(k, 1'b1)))
        cnt_d[k] = {wr_val[CNT_W-33:0], cnt_q[k][31:0]};
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NCNT; k++) begin
      if (rst) cnt_q[k] <= '0;
      else     cnt_q[k] <= cnt_d[k];
    end
  end
`endif

  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;
  assign mstatus_o  = mstatus_rd;
  assign irq_enable = mie_bit_q;

endmodule

// File: tb/tb_csr_trap_file.sv
// tb_csr_trap_file: directed and randomized checks of csr_trap_file against a behavioural CSR model.
// Builds with or without CSR_COUNTERS_EN; counter expectations follow the same macro.
module tb_csr_trap_file;

  localparam int          NUM_HPM   = 2;
  localparam int          CNT_W     = 40;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [63:0] CNT_MASK  = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);
`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [11:0]        csr_ra_id;
  logic [31:0]        csr_rd;
  logic               csr_illegal;
  logic               csr_we_ex;
  logic [1:0]         csr_op_ex;
  logic [11:0]        csr_wa_ex;
  logic [31:0]        csr_wd_ex;
  logic               instret_ex;
  logic [NUM_HPM-1:0] hpm_evt;
  logic               trap_valid;
  logic [31:0]        trap_cause;
  logic [31:0]        trap_pc;
  logic               mret_valid;
  logic [31:0]        mtvec_o, mepc_o, mstatus_o;
  logic               irq_enable;

  always #5 clk = ~clk;

  csr_trap_file #(.NUM_HPM(NUM_HPM), .CNT_W(CNT_W), .MTVEC_RST(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .csr_ra_id(csr_ra_id), .csr_rd(csr_rd), .csr_illegal(csr_illegal),
    .csr_we_ex(csr_we_ex), .csr_op_ex(csr_op_ex), .csr_wa_ex(csr_wa_ex), .csr_wd_ex(csr_wd_ex),
    .instret_ex(instret_ex), .hpm_evt(hpm_evt), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret_valid(mret_valid), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .mstatus_o(mstatus_o), .irq_enable(irq_enable)
  );

  // Reference model state
  bit          m_mie_b, m_mpie_b;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cnt [NUM_HPM+2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mstatus();
    return 32'h0000_1800 | (m_mpie_b ? 32'h80 : 32'h0) | (m_mie_b ? 32'h8 : 32'h0);
  endfunction

  // Returns counter index (0 mcycle, 1 minstret, 2.. hpm) or -1.
  function automatic int m_cnt_idx(input logic [11:0] a, output bit hi);
    logic [11:0] lo;
    hi = (a & 12'h080) != 12'h000;
    lo = a & ~12'h080;
    if (!CNT_EN) return -1;
    if (lo == 12'hB00) return 0;
    if (lo >= 12'hB02 && lo < 12'hB02 + 12'(NUM_HPM + 1)) return int'(lo - 12'hB01);
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit legal);
    bit hi;
    int k;
    legal = 1'b1;
    case (a)
      12'h300: return m_mstatus();
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF14: return 32'h0;
      default: begin
        k = m_cnt_idx(a, hi);
        if (k < 0) begin
          legal = 1'b0;
          return 32'h0;
        end
        return hi ? m_cnt[k][63:32] : m_cnt[k][31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] m_wval(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    logic [31:0] old, nv;
    bit lg, hi;
    int k;
    old = m_read(a, lg);
    nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
    case (a)
      12'h300: return (nv & 32'h88) | 32'h1800;
      12'h304: return nv & 32'h888;
      12'h305, 12'h341: return nv & 32'hFFFF_FFFC;
      12'h340, 12'h342: return nv;
      default: begin
        k = m_cnt_idx(a, hi);
        if (k < 0) return 32'h0;
        return hi ? (nv & 32'(CNT_MASK >> 32)) : nv;
      end
    endcase
  endfunction

  task automatic m_reset();
    m_mie_b = 0; m_mpie_b = 0;
    m_mie = 0; m_mtvec = MTVEC_RST & 32'hFFFF_FFFC; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    for (int k = 0; k < NUM_HPM + 2; k++) m_cnt[k] = 0;
  endtask

  // Apply one clock edge worth of architectural effects from the current inputs.
  task automatic m_step();
    bit wr, hi;
    int wk;
    logic [31:0] wv;
    logic [63:0] inc;
    if (rst) begin
      m_reset();
      return;
    end
    wr = csr_we_ex && csr_op_ex != 2'b00 && !trap_valid && !mret_valid;
    wv = m_wval(csr_wa_ex, csr_op_ex, csr_wd_ex);
    wk = m_cnt_idx(csr_wa_ex, hi);
    for (int k = 0; k < NUM_HPM + 2; k++) begin
      inc = (k == 0) ? 64'd1 : (k == 1) ? 64'(instret_ex) : 64'(hpm_evt[k-2]);
      if (wr && wk == k) begin
        if (hi) m_cnt[k] = ((64'(wv) << 32) | (m_cnt[k] & 64'hFFFF_FFFF)) & CNT_MASK;
        else    m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | 64'(wv);
      end else begin
        m_cnt[k] = (m_cnt[k] + inc) & CNT_MASK;
      end
    end
    if (trap_valid) begin
      m_mepc = trap_pc & 32'hFFFF_FFFC;
      m_mcause = trap_cause;
      m_mpie_b = m_mie_b;
      m_mie_b = 0;
    end else if (mret_valid) begin
      m_mie_b = m_mpie_b;
      m_mpie_b = 1;
    end else if (wr) begin
      case (csr_wa_ex)
        12'h300: begin m_mie_b = wv[3]; m_mpie_b = wv[7]; end
        12'h304: m_mie = wv;
        12'h305: m_mtvec = wv;
        12'h340: m_mscratch = wv;
        12'h341: m_mepc = wv;
        12'h342: m_mcause = wv;
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    rst = 0; csr_we_ex = 0; csr_op_ex = 0; csr_wa_ex = 0; csr_wd_ex = 0;
    instret_ex = 0; hpm_evt = 0; trap_valid = 0; trap_cause = 0; trap_pc = 0; mret_valid = 0;
  endtask

  task automatic ex_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_we_ex = 1; csr_op_ex = op; csr_wa_ex = a; csr_wd_ex = wd;
  endtask

  // Inputs are set at posedge+1; check against model, take the edge, advance model.
  task automatic cycle();
    logic [31:0] exp_rd;
    bit leg;
    #3;
    exp_rd = m_read(csr_ra_id, leg);
    if (csr_we_ex && csr_op_ex != 2'b00 && csr_wa_ex == csr_ra_id && !trap_valid && !mret_valid)
      exp_rd = m_wval(csr_wa_ex, csr_op_ex, csr_wd_ex);
    chk("csr_rd", csr_rd, exp_rd);
    chk("csr_illegal", csr_illegal, !leg);
    chk("mstatus_o", mstatus_o, m_mstatus());
    chk("mepc_o", mepc_o, m_mepc);
    chk("mtvec_o", mtvec_o, m_mtvec);
    chk("irq_enable", irq_enable, m_mie_b);
    @(posedge clk);
    m_step();
    #1;
  endtask

  logic [11:0] addrs [20] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                              12'h7C0, 12'h001, 12'hB00, 12'hB80, 12'hB01, 12'hB02, 12'hB82,
                              12'hB03, 12'hB83, 12'hB04, 12'hB84, 12'hB05, 12'hB85};

  initial begin
    idle();
    rst = 1;
    csr_ra_id = 12'h300;
    repeat (3) @(posedge clk);
    m_reset();
    #1;
    rst = 0;
    chk("rst_irq_enable", irq_enable, 1'b0);
    chk("rst_mstatus_o", mstatus_o, 32'h0000_1800);
    chk("rst_mepc_o", mepc_o, 32'h0);
    chk("rst_mtvec_o", mtvec_o, 32'h0000_1000);
    csr_ra_id = 12'h304; #1;
    chk("rst_mie", csr_rd, 32'h0);
    cycle();

    // mtvec low bits forced to zero
    ex_write(2'b01, 12'h305, 32'h8000_0103); csr_ra_id = 12'h305;
    cycle(); idle(); #1;
    chk("mtvec_rd", csr_rd, 32'h8000_0100);
    chk("mtvec_out", mtvec_o, 32'h8000_0100);
    cycle();

    // trap entry then mret
    ex_write(2'b01, 12'h300, 32'h0000_0088); cycle(); idle();
    chk("mstatus_set", mstatus_o, 32'h0000_1888);
    trap_valid = 1; trap_pc = 32'h0000_1006; trap_cause = 32'h8000_000B;
    cycle(); idle();
    chk("trap_mepc", mepc_o, 32'h0000_1004);
    chk("trap_mstatus", mstatus_o, 32'h0000_1880);
    chk("trap_irq", irq_enable, 1'b0);
    csr_ra_id = 12'h342; #1;
    chk("trap_mcause", csr_rd, 32'h8000_000B);
    mret_valid = 1; cycle(); idle();
    chk("mret_mstatus", mstatus_o, 32'h0000_1888);
    chk("mret_irq", irq_enable, 1'b1);

    // trap beats EX write in the same cycle
    ex_write(2'b01, 12'h340, 32'h1234_5678); cycle(); idle();
    trap_valid = 1; trap_pc = 32'h0000_2000; trap_cause = 32'h5;
    ex_write(2'b10, 12'h340, 32'h0000_00FF);
    cycle(); idle();
    csr_ra_id = 12'h340; #1;
    chk("trapprio_mscratch", csr_rd, 32'h1234_5678);
    chk("trapprio_mepc", mepc_o, 32'h0000_2000);
    chk("trapprio_mstatus", mstatus_o, 32'h0000_1880);

    // read bypass of RC and unimplemented address
    ex_write(2'b01, 12'h304, 32'hFFFF_FFFF); cycle(); idle();
    ex_write(2'b11, 12'h304, 32'h0000_0008); csr_ra_id = 12'h304; #1;
    chk("bypass_rc_mie", csr_rd, 32'h0000_0880);
    cycle(); idle();
    csr_ra_id = 12'h7C0; #1;
    chk("illegal_rd", csr_rd, 32'h0);
    chk("illegal_flag", csr_illegal, 1'b1);
    cycle();

`ifdef CSR_COUNTERS_EN
    ex_write(2'b01, 12'hB80, 32'h0000_00FF); cycle();
    ex_write(2'b01, 12'hB00, 32'hFFFF_FFFF); cycle(); idle();
    csr_ra_id = 12'hB00; #1;
    chk("mcycle_full_lo", csr_rd, 32'hFFFF_FFFF);
    cycle();
    csr_ra_id = 12'hB80; #1;
    chk("mcycle_wrap_hi", csr_rd, 32'h0);
    csr_ra_id = 12'hB00; #1;
    chk("mcycle_wrap_lo", csr_rd, 32'h0);
    ex_write(2'b01, 12'hB82, 32'hFFFF_FFFF); cycle(); idle();
    csr_ra_id = 12'hB82; #1;
    chk("minstret_hi_mask", csr_rd, 32'h0000_00FF);
    cycle();
`else
    csr_ra_id = 12'hB00; #1;
    chk("nocnt_rd", csr_rd, 32'h0);
    chk("nocnt_illegal", csr_illegal, 1'b1);
    cycle();
`endif

    for (int n = 0; n < 3000; n++) begin
      idle();
      rst        = ($urandom_range(0, 99) == 0);
      csr_ra_id  = addrs[$urandom_range(0, 19)];
      csr_we_ex  = ($urandom_range(0, 3) != 0);
      csr_op_ex  = 2'($urandom_range(0, 3));
      csr_wa_ex  = ($urandom_range(0, 3) == 0) ? csr_ra_id : addrs[$urandom_range(0, 19)];
      csr_wd_ex  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      instret_ex = 1'($urandom_range(0, 1));
      hpm_evt    = NUM_HPM'($urandom);
      trap_valid = ($urandom_range(0, 9) == 0);
      trap_cause = $urandom;
      trap_pc    = $urandom;
      mret_valid = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
